rah_rd_prefetch: RTL and testbench



---
 rtl/rah_rd_prefetch_if.sv | 49 ++++
 rtl/rah_rd_prefetch.sv | 98 +++++++++
 tb/tb_rah_rd_prefetch.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rah_rd_prefetch_if.sv
// -----------------------------------------------------------------------------
// rah_rd_prefetch_if
//   Signal bundle between a RAH per-app data-queue read port, the prefetch
//   block and the app compute logic that consumes the resulting stream.
//
//   Queue side : q_empty (queue empty flag), q_rden (read request),
//                q_data (read data, valid one cycle after q_rden)
//   Control    : flush (synchronous discard of buffered / in-flight words)
//   Stream side: m_valid, m_ready, m_data (oldest word first)
//   Status     : pkt_count (number of accepted stream handshakes)
//
//   master : the prefetch block itself
//   slave  : the surroundings (queue, consumer, control)
// -----------------------------------------------------------------------------
interface rah_rd_prefetch_if #(
    parameter int DATA_WIDTH = 48,
    parameter int CNT_WIDTH  = 32
);
    logic                  q_empty;
    logic                  q_rden;
    logic [DATA_WIDTH-1:0] q_data;
    logic                  flush;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [CNT_WIDTH-1:0]  pkt_count;

    modport master (
        input  q_empty,
        input  q_data,
        input  flush,
        input  m_ready,
        output q_rden,
        output m_valid,
        output m_data,
        output pkt_count
    );

    modport slave (
        output q_empty,
        output q_data,
        output flush,
        output m_ready,
        input  q_rden,
        input  m_valid,
        input  m_data,
        input  pkt_count
    );
endinterface

// File: rtl/rah_rd_prefetch.sv
// -----------------------------------------------------------------------------
// rah_rd_prefetch
//   Turns the empty/read-enable interface of a non-FWFT RAH data queue (one
//   cycle read latency) into a valid/ready stream. A 2-entry buffer absorbs the
//   read latency so one word per cycle is sustained without drops or
//   duplicates. Accepted handshakes are counted; flush discards everything
//   buffered or in flight.
//
//   Ports:
//     clk    : queue read clock and stream clock
//     rst_n  : asynchronous active-low reset
//     bus    : rah_rd_prefetch_if.master
//              q_empty/q_rden/q_data  queue read port
//              flush                  synchronous discard
//              m_valid/m_ready/m_data output stream
//              pkt_count              accepted handshake count (wraps)
// -----------------------------------------------------------------------------
module rah_rd_prefetch #(
    parameter int DATA_WIDTH = 48,
    parameter int CNT_WIDTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    rah_rd_prefetch_if.master bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Two-entry buffer; head is the word on m_data, tail the next free slot.
    logic [DATA_WIDTH-1:0] buf_mem [2];
    logic                  head;
    logic                  tail;
    logic [1:0]            occ;
    // Registered copy of q_rden: a word lands on q_data this cycle.
    logic                  in_flight;
    logic [CNT_WIDTH-1:0]  pkt_count_r;

    logic                  pop;
    logic                  capture;
    logic                  issue;
    logic [2:0]            committed;

    always_comb begin
        pop       = (occ != 2'd0) && bus.m_ready;
        capture   = in_flight && !bus.flush;
        // Slots already spoken for after this edge. pop implies occ >= 1, so
        // the subtraction cannot underflow.
        committed = {1'b0, occ} + {2'b00, in_flight} - {2'b00, pop};
        // A read is issued only when its word is sure to find a free slot, so
        // occ + in_flight never exceeds 2. rst_n gating keeps q_rden low while
        // the block is held in reset.
        issue     = rst_n && !bus.flush && !bus.q_empty && (committed < 3'd2);
    end

    assign bus.q_rden    = issue;
    assign bus.m_valid   = (occ != 2'd0);
    assign bus.m_data    = buf_mem[head];
    assign bus.pkt_count = pkt_count_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_mem[0]  <= '0;
            buf_mem[1]  <= '0;
            head        <= 1'b0;
            tail        <= 1'b0;
            occ         <= 2'd0;
            in_flight   <= 1'b0;
            pkt_count_r <= '0;
        end else begin
            in_flight <= issue;

            // A pop in the flush cycle is a real handshake and still counts.
            if (pop) begin
                pkt_count_r <= pkt_count_r + CNT_ONE;
            end

            if (bus.flush) begin
                // Buffered words are dropped; the in-flight word (if any) is
                // dropped because capture is suppressed this cycle.
                occ  <= 2'd0;
                head <= 1'b0;
                tail <= 1'b0;
            end else begin
                // Captured words always go through the buffer (no bypass), so
                // a word captured into an empty buffer shows up next cycle.
                if (capture) begin
                    buf_mem[tail] <= bus.q_data;
                    tail          <= ~tail;
                end
                if (pop) begin
                    head <= ~head;
                end
                occ <= occ + {1'b0, capture} - {1'b0, pop};
            end
        end
    end

endmodule

// File: tb/tb_rah_rd_prefetch.sv
// -----------------------------------------------------------------------------
// tb_rah_rd_prefetch
//   Bench for rah_rd_prefetch. A behavioural queue model feeds the DUT; every
//   loaded word is also pushed to an expected-word queue that is popped on each
//   stream handshake. A narrow counter width is used so counter wrap is reached
//   in a short run.
// -----------------------------------------------------------------------------
module tb_rah_rd_prefetch;

    localparam int DW = 48;
    localparam int CW = 8;

    typedef struct {
        logic          m_ready;
        logic          flush;
        logic          q_rden;
        logic          m_valid;
        logic          chk_data;
        logic [DW-1:0] m_data;
        logic [CW-1:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rah_rd_prefetch_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    rah_rd_prefetch #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int            n_vec = 0;
    int            n_bad = 0;
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    int            issued = 0;
    int            delivered = 0;
    int            discarded = 0;
    int            rd_pulses = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic          s_rd, s_pop, s_flush;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] hold_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Observe the settled pre-edge state.
    task automatic sample();
        s_rd    = bus.q_rden;
        s_pop   = bus.m_valid && bus.m_ready;
        s_flush = bus.flush;
        if (s_rd) rd_pulses++;
        chk("rden_while_empty", {63'd0, s_rd && bus.q_empty}, 64'd0);
        if (hold_prev) begin
            chk("hold_valid", {63'd0, bus.m_valid}, 64'd1);
            chk("hold_data", {16'd0, bus.m_data}, {16'd0, hold_data});
        end
        if (s_pop) begin
            if (exp_q.size() == 0) chk("unexpected_pop", 64'd1, 64'd0);
            else chk("pop_data", {16'd0, bus.m_data}, {16'd0, exp_q.pop_front()});
        end
        hold_prev = bus.m_valid && !bus.m_ready && !s_flush;
        hold_data = bus.m_data;
    endtask

    // Advance the queue model just after the edge.
    task automatic update();
        if (s_pop) begin
            delivered++;
            exp_cnt++;
        end
        if (s_flush) begin
            // Every word read but not yet handed out is gone.
            int n = issued - delivered - discarded;
            for (int i = 0; i < n; i++) void'(exp_q.pop_front());
            discarded += n;
        end
        if (s_rd && src_q.size() != 0) begin
            bus.q_data = src_q.pop_front();
            issued++;
        end
        bus.q_empty = (src_q.size() == 0);
        chk("occ_bound", {63'd0, (issued - delivered - discarded) > 2}, 64'd0);
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        update();
    endtask

    task automatic apply(input vec_t v, input string name);
        bus.m_ready = v.m_ready;
        bus.flush   = v.flush;
        @(negedge clk);
        chk({name, "_rden"},  {63'd0, bus.q_rden},  {63'd0, v.q_rden});
        chk({name, "_valid"}, {63'd0, bus.m_valid}, {63'd0, v.m_valid});
        if (v.chk_data) chk({name, "_data"}, {16'd0, bus.m_data}, {16'd0, v.m_data});
        chk({name, "_cnt"}, {56'd0, bus.pkt_count}, {56'd0, v.cnt});
        sample();
        @(posedge clk);
        #1;
        update();
    endtask

    task automatic load(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            src_q.push_back(base + DW'(i));
            exp_q.push_back(base + DW'(i));
        end
        bus.q_empty = (src_q.size() == 0);
    endtask

    task automatic drain(input int budget, input bit toggle);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            if (toggle) bus.m_ready = ~bus.m_ready;
            tick();
            k++;
        end
        chk("drain_timeout", {63'd0, exp_q.size() != 0}, 64'd0);
    endtask

    vec_t t_idle[10];
    vec_t t_lat[7];

    initial begin
        bus.q_empty = 1'b1;
        bus.q_data  = '0;
        bus.flush   = 1'b0;
        bus.m_ready = 1'b0;

        for (int i = 0; i < 10; i++) t_idle[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0};
        t_lat[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 48'h0, 8'd0};
        t_lat[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 48'h0, 8'd0};
        t_lat[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 48'h1, 8'd0};
        t_lat[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 48'h2, 8'd1};
        t_lat[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 48'h3, 8'd2};
        t_lat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 48'h4, 8'd3};
        t_lat[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0, 8'd4};

        // Reset state
        #2;
        chk("rst_rden",  {63'd0, bus.q_rden},  64'd0);
        chk("rst_valid", {63'd0, bus.m_valid}, 64'd0);
        chk("rst_data",  {16'd0, bus.m_data},  64'd0);
        chk("rst_cnt",   {56'd0, bus.pkt_count}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: idle
        for (int i = 0; i < 10; i++) apply(t_idle[i], "idle");

        // 2: latency and full-rate delivery of 1..4
        load(48'h1, 4);
        for (int i = 0; i < 7; i++) apply(t_lat[i], "lat");

        // 3: consumer stalled for 6 cycles
        load(48'h11, 4);
        bus.m_ready = 1'b0;
        rd_pulses = 0;
        repeat (6) tick();
        chk("stall_rd_pulses", 64'(rd_pulses), 64'd2);
        chk("stall_valid", {63'd0, bus.m_valid}, 64'd1);
        chk("stall_data", {16'd0, bus.m_data}, 64'h11);
        bus.m_ready = 1'b1;
        drain(50, 1'b0);
        chk("stall_cnt", {56'd0, bus.pkt_count}, 64'd8);

        // 4: 100 words against toggling m_ready
        load(48'h1000, 100);
        bus.m_ready = 1'b0;
        drain(1000, 1'b1);
        chk("toggle_cnt", {56'd0, bus.pkt_count}, 64'd108);

        // 5: flush with one buffered word and one in flight
        load(48'h21, 6);
        bus.m_ready = 1'b0;
        repeat (4) tick();
        chk("pre_flush_valid", {63'd0, bus.m_valid}, 64'd1);
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_valid", {63'd0, bus.m_valid}, 64'd0);
        chk("flush_cnt", {56'd0, bus.pkt_count}, 64'd109);
        chk("flush_exp_next", {16'd0, exp_q[0]}, 64'h24);
        tick();
        chk("flush_valid2", {63'd0, bus.m_valid}, 64'd0);
        bus.m_ready = 1'b1;
        drain(50, 1'b0);
        chk("resume_cnt", {56'd0, bus.pkt_count}, 64'd112);

        // 6: counter wrap, then reset mid-stream
        load(48'h2000, 255 - int'(exp_cnt));
        drain(600, 1'b0);
        chk("cnt_max", {56'd0, bus.pkt_count}, 64'hFF);
        load(48'h3000, 1);
        drain(20, 1'b0);
        repeat (2) tick();
        chk("cnt_wrap", {56'd0, bus.pkt_count}, 64'd0);
        load(48'h4000, 10);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_rden",  {63'd0, bus.q_rden},  64'd0);
        chk("midrst_valid", {63'd0, bus.m_valid}, 64'd0);
        chk("midrst_data",  {16'd0, bus.m_data},  64'd0);
        chk("midrst_cnt",   {56'd0, bus.pkt_count}, 64'd0);
        src_q.delete();
        exp_q.delete();
        issued = 0;
        delivered = 0;
        discarded = 0;
        exp_cnt = '0;
        hold_prev = 1'b0;
        bus.q_empty = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        load(48'h31, 3);
        drain(20, 1'b0);
        chk("post_rst_cnt", {56'd0, bus.pkt_count}, 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
